// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC generator: exception/eret/branch/stall arbitration
// with a held redirect for branches that resolve during a stall.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IM_BASE   = 32'h0000_3000,
   parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stopen,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] PC_out,
   output logic [31:0] pc_plus8,
   output logic        adel_f,
   output logic        redirect_pending
);

   typedef enum logic {RUN, PEND} state_t;

   state_t      state;
   logic [31:0] pend_target;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         PC_out           <= RESET_PC;
         state            <= RUN;
         pend_target      <= '0;
         redirect_pending <= 1'b0;
      end else if (exc_req) begin
         PC_out           <= EXC_ENTRY;
         state            <= RUN;
         redirect_pending <= 1'b0;
      end else if (eret_req) begin
         PC_out           <= epc;
         state            <= RUN;
         redirect_pending <= 1'b0;
      end else if (stopen) begin
         // the branch's delay slot is frozen in F; keep the target for later
         if (br_valid) begin
            pend_target      <= br_target;
            state            <= PEND;
            redirect_pending <= 1'b1;
         end
      end else if (br_valid) begin
         PC_out           <= br_target;
         state            <= RUN;
         redirect_pending <= 1'b0;
      end else if (state == PEND) begin
         PC_out           <= pend_target;
         state            <= RUN;
         redirect_pending <= 1'b0;
      end else begin
         PC_out <= PC_out + 32'd4;
      end
   end

   assign pc_plus8 = PC_out + 32'd8;

   assign adel_f = (PC_out[1:0] != 2'b00) |
                   (PC_out < IM_BASE)     |
                   (PC_out > IM_LIMIT);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed and randomized checks of fetch_pc_unit against a
// queue-based reference of the next-PC rules.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stopen;
   logic        br_valid;
   logic [31:0] br_target;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] PC_out;
   logic [31:0] pc_plus8;
   logic        adel_f;
   logic        redirect_pending;

   int total  = 0;
   int passed = 0;

   logic [31:0] m_pc;
   logic [31:0] held[$];

   fetch_pc_unit dut (
      .clk              (clk),
      .reset            (reset),
      .stopen           (stopen),
      .br_valid         (br_valid),
      .br_target        (br_target),
      .exc_req          (exc_req),
      .eret_req         (eret_req),
      .epc              (epc),
      .PC_out           (PC_out),
      .pc_plus8         (pc_plus8),
      .adel_f           (adel_f),
      .redirect_pending (redirect_pending)
   );

   always #5 clk = ~clk;

   function automatic logic m_adel(input logic [31:0] p);
      return (p % 4 != 0) || (p < 32'h3000) || (p > 32'h6FFC);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".pc"}, PC_out, m_pc);
      chk({tag, ".pc8"}, pc_plus8, m_pc + 32'd8);
      chk({tag, ".adel"}, {31'd0, adel_f}, {31'd0, m_adel(m_pc)});
      chk({tag, ".pend"}, {31'd0, redirect_pending},
          {31'd0, held.size() != 0});
   endtask

   task automatic model_reset();
      m_pc = 32'h3000;
      held.delete();
   endtask

   task automatic model_edge();
      if (reset) model_reset();
      else if (exc_req) begin
         m_pc = 32'h4180;
         held.delete();
      end else if (eret_req) begin
         m_pc = epc;
         held.delete();
      end else if (stopen) begin
         if (br_valid) begin
            held.delete();
            held.push_back(br_target);
         end
      end else if (br_valid) begin
         m_pc = br_target;
         held.delete();
      end else if (held.size() != 0) m_pc = held.pop_front();
      else m_pc = m_pc + 32'd4;
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      chk_all(tag);
   endtask

   task automatic idle();
      stopen    = 1'b0;
      br_valid  = 1'b0;
      br_target = '0;
      exc_req   = 1'b0;
      eret_req  = 1'b0;
      epc       = '0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      model_reset();
      #12;
      chk_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // T1
      step("t1a");
      step("t1b");
      chk("t1_seq", PC_out, 32'h3008);

      // T2
      stopen = 1'b1;
      repeat (3) step("t2_stall");
      chk("t2_hold", PC_out, 32'h3008);
      stopen = 1'b0;
      step("t2_go");

      // T3
      br_valid  = 1'b1;
      br_target = 32'h3100;
      step("t3_br");
      chk("t3_tgt", PC_out, 32'h3100);
      stopen    = 1'b1;
      br_target = 32'h3200;
      step("t3_pend");
      br_valid = 1'b0;
      repeat (2) step("t3_hold");
      chk("t3_pflag", {31'd0, redirect_pending}, 32'd1);
      stopen = 1'b0;
      step("t3_rel");
      chk("t3_rtgt", PC_out, 32'h3200);

      // T4: exception discards the held redirect
      stopen    = 1'b1;
      br_valid  = 1'b1;
      br_target = 32'h3300;
      step("t4_pend");
      br_valid = 1'b0;
      exc_req  = 1'b1;
      step("t4_exc");
      exc_req = 1'b0;
      stopen  = 1'b0;
      step("t4_next");
      chk("t4_seq", PC_out, 32'h4184);

      // T5
      eret_req = 1'b1;
      epc      = 32'h3010;
      step("t5_eret");
      exc_req = 1'b1;
      step("t5_both");
      chk("t5_prio", PC_out, 32'h4180);
      idle();

      // T6 address-error boundaries and wrap
      br_valid = 1'b1;
      br_target = 32'h3002;
      step("t6_mis");
      br_target = 32'h7000;
      step("t6_hi");
      br_target = 32'h6FFC;
      step("t6_lim");
      br_target = 32'h2FFC;
      step("t6_lo");
      br_target = 32'hFFFF_FFFC;
      step("t6_top");
      br_valid = 1'b0;
      step("t6_wrap");
      chk("t6_zero", PC_out, 32'h0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         stopen   = ($urandom_range(0, 99) < 40);
         br_valid = ($urandom_range(0, 99) < 30);
         exc_req  = ($urandom_range(0, 99) < 4);
         eret_req = ($urandom_range(0, 99) < 4);
         if ($urandom_range(0, 9) == 0) br_target = $urandom;
         else br_target = 32'h3000 + ($urandom_range(0, 16383) & 32'hFFFC);
         epc = 32'h3000 + ($urandom_range(0, 4095) << 2);
         step("rand");
      end
      idle();

      // T6: async reset while a redirect is held
      stopen    = 1'b1;
      br_valid  = 1'b1;
      br_target = 32'h3400;
      step("t6_pend");
      chk("t6_pflag", {31'd0, redirect_pending}, 32'd1);
      idle();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      chk_all("t6_async");
      @(negedge clk);
      reset = 1'b0;
      step("t6_after");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
